// File: rtl/rnn_mem_responder.sv
// -----------------------------------------------------------------------------
// rnn_mem_responder
//   Memory-side responder for an RNN initiator. It holds the weights, biases,
//   sequence info, the per-step output rows and the input word stream. A
//   loader port fills the banks while the block is idle, and then arms a run.
//   During a run the initiator reads through a zero-latency combinational port,
//   writes output rows, and pulls input words one at a time.
//
// Configuration macro:
//   RNN_MEM_ERRCHK_EN - when defined, a sticky error flag records illegal
//                       accesses. When undefined, err is tied low.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   mce/msel/maddr        initiator access: enable, bank select, word address
//   mdata_w / mdata_r     initiator write data / combinational read data
//   i_en / idata          input-word advance / current input word
//   busy / ready          initiator running / data loaded and start permitted
//   ld_valid/ld_sel/ld_addr/ld_data/ld_ready
//                         loader write handshake (IDLE and DONE only)
//   ld_go                 loading finished, arm the run
//   rd_addr / rd_data     registered readback of the output bank
//   done / err            run finished / sticky access error
// -----------------------------------------------------------------------------
module rnn_mem_responder #(
  parameter int T_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mce,
  input  logic [2:0]  msel,
  input  logic [16:0] maddr,
  input  logic [19:0] mdata_w,
  output logic [19:0] mdata_r,
  input  logic        i_en,
  output logic [31:0] idata,
  input  logic        busy,
  output logic        ready,
  input  logic        ld_valid,
  input  logic [2:0]  ld_sel,
  input  logic [16:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_go,
  input  logic [16:0] rd_addr,
  output logic [19:0] rd_data,
  output logic        done,
  output logic        err
);

  localparam int IW = $clog2(T_MAX);  // input-word index width
  localparam int OW = IW + 6;         // output-bank index width: {t, h[5:0]}
  localparam logic [17:0] OUT_DEPTH = 18'(64 * T_MAX);
  localparam logic [17:0] IN_DEPTH  = 18'(T_MAX);

  localparam logic [2:0] SEL_WIH  = 3'b000;
  localparam logic [2:0] SEL_BIH  = 3'b001;
  localparam logic [2:0] SEL_WHH  = 3'b010;
  localparam logic [2:0] SEL_BHH  = 3'b011;
  localparam logic [2:0] SEL_INFO = 3'b100;
  localparam logic [2:0] SEL_OUT  = 3'b101;
  localparam logic [2:0] SEL_IN   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Storage. None of it is reset: contents survive an aborted run.
  logic [19:0] w_ih_mem [0:2047];
  logic [19:0] b_ih_mem [0:63];
  logic [19:0] w_hh_mem [0:4095];
  logic [19:0] b_hh_mem [0:63];
  logic [19:0] info_mem;
  logic [19:0] out_mem  [0:64*T_MAX-1];
  logic [31:0] in_mem   [0:T_MAX-1];

  state_t      state_q, state_d;
  logic [IW:0] ptr_q, ptr_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [19:0] rd_data_q, rd_data_d;

  // Address legality per bank. The address is zero-extended so the compare
  // against the output-bank depth also works when T_MAX makes it 2^17.
  function automatic logic in_range(input logic [2:0] sel, input logic [16:0] a);
    logic [17:0] ax;
    ax = {1'b0, a};
    case (sel)
      SEL_WIH:          return ax < 18'd2048;
      SEL_BIH, SEL_BHH: return ax < 18'd64;
      SEL_WHH:          return ax < 18'd4096;
      SEL_INFO:         return ax == 18'd0;
      SEL_OUT:          return ax < OUT_DEPTH;
      SEL_IN:           return ax < IN_DEPTH;
      default:          return 1'b0;
    endcase
  endfunction

  logic m_ok, ld_ok, rd_ok, ld_fire;

  assign m_ok     = in_range(msel, maddr);
  assign ld_ok    = in_range(ld_sel, ld_addr);
  assign rd_ok    = in_range(SEL_OUT, rd_addr);
  assign ld_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign ld_fire  = ld_valid && ld_ready;

  // ---------------------------------------------------------------------------
  // Memory writes. The loader never targets the output bank and the initiator
  // only writes the output bank, so every array has a single write port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_fire && ld_ok) begin
      case (ld_sel)
        SEL_WIH:  w_ih_mem[ld_addr[10:0]] <= ld_data[19:0];
        SEL_BIH:  b_ih_mem[ld_addr[5:0]]  <= ld_data[19:0];
        SEL_WHH:  w_hh_mem[ld_addr[11:0]] <= ld_data[19:0];
        SEL_BHH:  b_hh_mem[ld_addr[5:0]]  <= ld_data[19:0];
        SEL_INFO: info_mem                <= ld_data[19:0];
        SEL_IN:   in_mem[ld_addr[IW-1:0]] <= ld_data;
        default: ;
      endcase
    end
    // Served in every state; the initiator owns the timing of its accesses.
    if (mce && (msel == SEL_OUT) && m_ok)
      out_mem[maddr[OW-1:0]] <= mdata_w;
  end

  // ---------------------------------------------------------------------------
  // Zero-latency initiator read. The output and input banks are not readable
  // here, so they return zero along with disabled or out-of-range accesses.
  // ---------------------------------------------------------------------------
  always_comb begin
    mdata_r = '0;
    if (mce && m_ok) begin
      case (msel)
        SEL_WIH:  mdata_r = w_ih_mem[maddr[10:0]];
        SEL_BIH:  mdata_r = b_ih_mem[maddr[5:0]];
        SEL_WHH:  mdata_r = w_hh_mem[maddr[11:0]];
        SEL_BHH:  mdata_r = b_hh_mem[maddr[5:0]];
        SEL_INFO: mdata_r = info_mem;
        default:  mdata_r = '0;
      endcase
    end
  end

  // ptr saturates at T_MAX, so its top bit alone flags an exhausted stream.
  assign idata = ptr_q[IW] ? 32'd0 : in_mem[ptr_q[IW-1:0]];

  // ---------------------------------------------------------------------------
  // Control: next state, stream pointer and registered status.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE:  if (ld_go) state_d = S_READY;
      S_READY: if (busy)  state_d = S_RUN;
      S_RUN: begin
        if (i_en && !ptr_q[IW]) ptr_d = ptr_q + 1'b1;
        if (!busy) state_d = S_DONE;
      end
      S_DONE: begin
        // A re-arm wins over a new load; the load itself still lands.
        if (ld_go)         state_d = S_READY;
        else if (ld_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Every new arm restarts the input stream from word 0.
    if ((state_d == S_READY) && (state_q != S_READY)) ptr_d = '0;

    ready_d   = (state_d == S_READY);
    done_d    = (state_d == S_DONE);
    // Sampled before this edge's output write, so a same-address readback
    // returns the old contents.
    rd_data_d = rd_ok ? out_mem[rd_addr[OW-1:0]] : 20'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;

  // ---------------------------------------------------------------------------
  // Optional sticky error: initiator touching loader-only or unused banks,
  // out-of-range addresses, or pulling past the end of the input stream.
  // ---------------------------------------------------------------------------
`ifdef RNN_MEM_ERRCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (mce && ((msel[2:1] == 2'b11) || !m_ok)) err_d = 1'b1;
    if (i_en && ptr_q[IW])                      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Self-checking bench for rnn_mem_responder. Loads banks, runs a sequence,
// checks the read port, input stream, output readback, FSM and reset.
module tb_rnn_mem_responder;
  localparam int T_MAX = 16;
`ifdef RNN_MEM_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mce = 1'b0;
  logic [2:0]  msel = '0;
  logic [16:0] maddr = '0;
  logic [19:0] mdata_w = '0;
  logic [19:0] mdata_r;
  logic        i_en = 1'b0;
  logic [31:0] idata;
  logic        busy = 1'b0;
  logic        ready;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_sel = '0;
  logic [16:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        ld_go = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [19:0] rd_data;
  logic        done;
  logic        err;

  rnn_mem_responder #(.T_MAX(T_MAX)) dut (
    .clk(clk), .reset(reset),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
    .i_en(i_en), .idata(idata), .busy(busy), .ready(ready),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_go(ld_go),
    .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic [2:0]  sel;
    logic [16:0] addr;
    logic [19:0] val;
  } rd_t;
  typedef struct {
    logic [16:0] addr;
    logic [19:0] val;
  } ob_t;

  rd_t         mem_sb[$];   // expected mdata_r per access
  ob_t         out_sb[$];   // expected rd_data per readback address
  logic [31:0] in_sb[$];    // expected idata sequence
  logic [31:0] in_model [T_MAX];

  task automatic sb_push(input logic [2:0] s, input logic [16:0] a, input logic [19:0] v);
    rd_t e;
    e.sel = s; e.addr = a; e.val = v;
    mem_sb.push_back(e);
  endtask

  // Called right after a negedge; the transfer happens at the following posedge.
  task automatic load(input logic [2:0] s, input logic [16:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    total++;
    if ({ready, done, err, ld_ready} !== 4'b0001) begin
      bad++; $display("FAIL reset_flags: got %b want 0001", {ready, done, err, ld_ready});
    end
    total++;
    if (rd_data !== 20'd0) begin
      bad++; $display("FAIL reset_rd_data: got %h want 00000", rd_data);
    end
    total++;
    if (mdata_r !== 20'd0) begin
      bad++; $display("FAIL reset_mdata_r: got %h want 00000", mdata_r);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_read;
    rd_t e;
    load(3'd0, 17'h00000, 32'h0000_0AAA); sb_push(3'd0, 17'h00000, 20'h00AAA);
    load(3'd0, 17'h00065, 32'h0001_2345); sb_push(3'd0, 17'h00065, 20'h12345);
    load(3'd0, 17'h00800, 32'h0005_5555); sb_push(3'd0, 17'h00800, 20'h00000);
    load(3'd2, 17'h00ABC, 32'hFFF0_BEEF); sb_push(3'd2, 17'h00ABC, 20'h0BEEF);
    load(3'd1, 17'h0003F, 32'h0000_0111); sb_push(3'd1, 17'h0003F, 20'h00111);
    load(3'd3, 17'h00000, 32'h0000_0222); sb_push(3'd3, 17'h00000, 20'h00222);
    sb_push(3'd3, 17'h00040, 20'h00000);
    load(3'd4, 17'h00000, 32'h0000_0004); sb_push(3'd4, 17'h00000, 20'h00004);
    sb_push(3'd4, 17'h00001, 20'h00000);
    sb_push(3'd5, 17'h00000, 20'h00000);
    sb_push(3'd6, 17'h00000, 20'h00000);
    sb_push(3'd7, 17'h00000, 20'h00000);
    for (int i = 0; i < T_MAX; i++) begin
      in_model[i] = (i < 4) ? 32'hA + 32'(i) : 32'hC0DE_0000 + 32'(i);
      load(3'd6, 17'(i), in_model[i]);
    end
    load(3'd6, 17'(T_MAX), 32'h0BAD_0BAD);  // out of range, must not alias word 0
    ld_go = 1'b1;
    @(negedge clk);
    ld_go = 1'b0;
    #1;
    total++;
    if ({ready, ld_ready, done} !== 3'b100) begin
      bad++; $display("FAIL go_ready: got %b want 100", {ready, ld_ready, done});
    end
    while (mem_sb.size() > 0) begin
      e = mem_sb.pop_front();
      @(negedge clk);
      mce = 1'b1; msel = e.sel; maddr = e.addr;
      #1;
      total++;
      if (mdata_r !== e.val) begin
        bad++; $display("FAIL mem_read sel=%0d addr=%h: got %h want %h", e.sel, e.addr, mdata_r, e.val);
      end
    end
    @(negedge clk);
    mce = 1'b0; msel = 3'd0; maddr = 17'h00065;
    #1;
    total++;
    if (mdata_r !== 20'd0) begin
      bad++; $display("FAIL mce_off_read: got %h want 00000", mdata_r);
    end
    exp_err = ERRCHK;  // several out-of-range / illegal-bank accesses above
  endtask

  task automatic test_stream;
    logic [31:0] e;
    for (int i = 0; i < T_MAX; i++) in_sb.push_back(in_model[i]);
    in_sb.push_back(32'd0);
    in_sb.push_back(32'd0);
    @(negedge clk); busy = 1'b1;
    @(negedge clk); #1;
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_busy: got %b want 0", ready);
    end
    e = in_sb.pop_front();
    total++;
    if (idata !== e) begin
      bad++; $display("FAIL idata_first: got %h want %h", idata, e);
    end
    for (int k = 1; k <= T_MAX + 1; k++) begin
      i_en = 1'b1;
      @(negedge clk);
      i_en = 1'b0;
      #1;
      e = in_sb.pop_front();
      total++;
      if (idata !== e) begin
        bad++; $display("FAIL idata_step%0d: got %h want %h", k, idata, e);
      end
    end
    exp_err = ERRCHK;
    total++;
    if (err !== exp_err) begin
      bad++; $display("FAIL err_after_stream: got %b want %b", err, exp_err);
    end
  endtask

  task automatic test_write_readback;
    ob_t o;
    @(negedge clk);
    mce = 1'b1; msel = 3'd5; maddr = 17'h00047; mdata_w = 20'hFFFFF;
    #1;
    total++;
    if (mdata_r !== 20'd0) begin
      bad++; $display("FAIL out_bank_mdata_r: got %h want 00000", mdata_r);
    end
    @(negedge clk);
    mdata_w = 20'h12121; rd_addr = 17'h00047;
    @(negedge clk); #1;
    total++;
    if (rd_data !== 20'hFFFFF) begin
      bad++; $display("FAIL same_cycle_rd_old: got %h want fffff", rd_data);
    end
    maddr = 17'h00447; mdata_w = 20'h33333;  // out of range, must not alias 0x47
    @(negedge clk);
    maddr = 17'h003FF; mdata_w = 20'h0ABCD;
    @(negedge clk);
    mce = 1'b0;
    o.addr = 17'h00047; o.val = 20'h12121; out_sb.push_back(o);
    o.addr = 17'h003FF; o.val = 20'h0ABCD; out_sb.push_back(o);
    o.addr = 17'h00400; o.val = 20'h00000; out_sb.push_back(o);
    o.addr = 17'h00047; o.val = 20'h12121; out_sb.push_back(o);
    while (out_sb.size() > 0) begin
      o = out_sb.pop_front();
      rd_addr = o.addr;
      @(negedge clk);
      total++;
      if (rd_data !== o.val) begin
        bad++; $display("FAIL readback addr=%h: got %h want %h", o.addr, rd_data, o.val);
      end
    end
    busy = 1'b0;
    @(negedge clk);
    total++;
    if ({done, ready, ld_ready} !== 3'b101) begin
      bad++; $display("FAIL run_done: got %b want 101", {done, ready, ld_ready});
    end
  endtask

  task automatic test_done_reload;
    load(3'd1, 17'h00001, 32'h0000_0321);  // DONE -> IDLE on a load
    #1;
    total++;
    if ({done, ready, ld_ready} !== 3'b001) begin
      bad++; $display("FAIL done_to_idle: got %b want 001", {done, ready, ld_ready});
    end
    ld_go = 1'b1;
    @(negedge clk);
    ld_go = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL rearm_ready: got %b want 1", ready);
    end
    total++;
    if (idata !== in_model[0]) begin
      bad++; $display("FAIL ptr_cleared: got %h want %h", idata, in_model[0]);
    end
    mce = 1'b1; msel = 3'd1; maddr = 17'h00001;
    #1;
    total++;
    if (mdata_r !== 20'h00321) begin
      bad++; $display("FAIL reload_read: got %h want 00321", mdata_r);
    end
    mce = 1'b0;
    @(negedge clk);
    total++;
    if (rd_data !== 20'h12121) begin
      bad++; $display("FAIL out_retained: got %h want 12121", rd_data);
    end
  endtask

  task automatic test_run_blocks_loader;
    @(negedge clk); busy = 1'b1;
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = 3'd0; ld_addr = 17'h00065; ld_data = 32'h0007_7777;
    #1;
    total++;
    if (ld_ready !== 1'b0) begin
      bad++; $display("FAIL run_ld_ready: got %b want 0", ld_ready);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    mce = 1'b1; msel = 3'd0; maddr = 17'h00065;
    #1;
    total++;
    if (mdata_r !== 20'h12345) begin
      bad++; $display("FAIL run_load_dropped: got %h want 12345", mdata_r);
    end
    mce = 1'b0;
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    total++;
    if (rd_data !== 20'h12121) begin
      bad++; $display("FAIL pre_reset_rd: got %h want 12121", rd_data);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ready, done, err, ld_ready} !== 4'b0001) begin
      bad++; $display("FAIL async_reset_flags: got %b want 0001", {ready, done, err, ld_ready});
    end
    total++;
    if (rd_data !== 20'd0) begin
      bad++; $display("FAIL async_reset_rd: got %h want 00000", rd_data);
    end
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0; busy = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({ready, idata} !== {1'b0, in_model[0]}) begin
      bad++; $display("FAIL post_reset_idle: got %b/%h want 0/%h", ready, idata, in_model[0]);
    end
    mce = 1'b1; msel = 3'd2; maddr = 17'h00ABC;
    #1;
    total++;
    if (mdata_r !== 20'h0BEEF) begin
      bad++; $display("FAIL w_hh_kept: got %h want 0beef", mdata_r);
    end
    mce = 1'b0;
  endtask

  task automatic test_go_with_load;
    @(negedge clk);
    ld_valid = 1'b1; ld_go = 1'b1; ld_sel = 3'd3; ld_addr = 17'h00005; ld_data = 32'h0000_2468;
    @(negedge clk);
    ld_valid = 1'b0; ld_go = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL go_load_ready: got %b want 1", ready);
    end
    mce = 1'b1; msel = 3'd3; maddr = 17'h00005;
    #1;
    total++;
    if (mdata_r !== 20'h02468) begin
      bad++; $display("FAIL go_load_data: got %h want 02468", mdata_r);
    end
    mce = 1'b0;
    // Short run, then re-arm straight from DONE.
    @(negedge clk); busy = 1'b1;
    @(negedge clk); busy = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL short_run_done: got %b want 1", done);
    end
    ld_go = 1'b1;
    @(negedge clk);
    ld_go = 1'b0;
    #1;
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL done_to_ready: got %b want 10", {ready, done});
    end
  endtask

  task automatic test_err;
    @(negedge clk);
    mce = 1'b1; msel = 3'd6; maddr = 17'h00000;
    #1;
    total++;
    if ({mdata_r, err} !== {20'd0, exp_err}) begin
      bad++; $display("FAIL err_pre: got %h/%b want 00000/%b", mdata_r, err, exp_err);
    end
    @(negedge clk);
    mce = 1'b0;
    exp_err = ERRCHK;
    #1;
    total++;
    if (err !== exp_err) begin
      bad++; $display("FAIL err_set: got %b want %b", err, exp_err);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (err !== exp_err) begin
      bad++; $display("FAIL err_held: got %b want %b", err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_stream();
    test_write_readback();
    test_done_reload();
    test_run_blocks_loader();
    test_reset_midrun();
    test_go_with_load();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/rnn_mem_responder.md
RNN_MEM_RESPONDER -- requirements
Module: rnn_mem_responder

Interface
REQ-001 Parameter: T_MAX, 16, max time steps held (input words and output rows); power of two, 2..2048.
REQ-002 Ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-003 Ports: mce  in  1  memory access enable from initiator; msel  in  3  bank select; maddr  in  17  word address; mdata_w  in  20  write data; mdata_r  out  20  read data.
REQ-004 Ports: i_en  in  1  input-word request; idata  out  32  current input word; busy  in  1  initiator running; ready  out  1  data loaded, start permitted.
REQ-005 Ports: ld_valid  in  1; ld_sel  in  3  target bank; ld_addr  in  17; ld_data  in  32; ld_ready  out  1; ld_go  in  1  load complete, arm run.
REQ-006 Ports: rd_addr  in  17  output-bank readback address; rd_data  out  20  readback data; done  out  1  run finished; err  out  1  sticky access error.

Function
REQ-010 Bank map by msel/ld_sel: 000 W_ih 2048x20, addr {h[5:0],x[4:0]}; 001 b_ih 64x20; 010 W_hh 4096x20, addr {h[5:0],k[5:0]}; 011 b_hh 64x20; 100 info, addr 0 = sequence length T; 101 output 64*T_MAX x20, addr {t,h[5:0]}; 110 input words T_MAX x32 (loader only).
REQ-011 Read: mdata_r is combinational from current mce, msel, maddr; zero-cycle latency, so an address driven at edge N is valid data before edge N+1.
REQ-012 mdata_r = 0 when mce=0, msel=101, msel>=110, or address out of range.
REQ-013 Write: at rising edge with mce=1 and msel=101, mdata_w stored at output[maddr]; any other msel never writes.
REQ-014 Input stream: idata = input[ptr]; ptr increments at each rising edge sampling i_en=1 in RUN; idata = 0 once ptr >= T_MAX, ptr saturates at T_MAX.
REQ-015 Loader: transfer on rising edge with ld_valid=1 and ld_ready=1; 20-bit banks take ld_data[19:0]; bank 110 takes 32 bits; out-of-range or sel 101/111 loads are dropped.
REQ-016 FSM states IDLE, READY, RUN, DONE; ld_ready=1 only in IDLE and DONE.
REQ-017 IDLE -> READY on ld_go; READY -> RUN on busy=1; RUN -> DONE on busy=0; DONE -> READY on ld_go; DONE -> IDLE on ld_valid transfer.
REQ-018 ready=1 exactly in READY; done=1 exactly in DONE; both registered.
REQ-019 Entering READY clears ptr to 0; output bank contents retained.
REQ-020 Accesses with mce=1 outside RUN are served identically (no state-based gating of reads/writes).
REQ-021 ld_go and ld_valid in same cycle in IDLE: load performed, FSM -> READY.
REQ-022 rd_data registered: rd_data = output[rd_addr] one cycle after rd_addr presented; 0 if out of range.
REQ-023 Same-cycle write and readback of same address: rd_data returns pre-write value.

Reset
REQ-030 reset asserted: FSM -> IDLE, ptr=0, ready=0, done=0, err=0, rd_data=0 immediately, independent of clk.
REQ-031 Memory arrays not cleared by reset; reset mid-RUN aborts run, subsequent reads return previously loaded contents.

Configuration
REQ-040 Macro RNN_MEM_ERRCHK_EN defined: err set and held until reset on mce=1 with msel 110/111, out-of-range maddr, or i_en=1 with ptr=T_MAX.
REQ-041 Macro undefined: err tied 0, no checking logic; data behaviour of REQ-012/014 unchanged.

Verification
REQ-050 Load W_ih[{3,5}]=0x12345, info[0]=4, ld_go -> ready=1 next cycle; mce=1,msel=000,maddr=0x065 -> mdata_r=0x12345 same cycle.
REQ-051 Load input words 0xA..0xD, ld_go, busy=1; pulse i_en 3 times -> idata sequence 0xA,0xB,0xC,0xD; ready=0 after busy seen.
REQ-052 mce=1,msel=101,maddr=0x0047,mdata_w=0xFFFFF; then rd_addr=0x0047 -> rd_data=0xFFFFF one cycle later; busy falls -> done=1.
REQ-053 Reset asserted mid-RUN -> ready/done/err=0 without clock edge; FSM IDLE; earlier W_hh contents still read back.
REQ-054 With RNN_MEM_ERRCHK_EN: msel=110,mce=1 -> err=1 held; mdata_r=0. Without macro: same stimulus -> err=0.
REQ-055 ld_valid during RUN -> ld_ready=0, bank unchanged; ld_go with ld_valid in IDLE -> data stored and ready=1.
